// File: rtl/pic_pkg.sv
// Shared constants, opcode patterns and control-flow classification for the
// baseline PIC fetch/sequencing logic.
package pic_pkg;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned INSTR_W = 12;

  localparam logic [11:0] NOP = 12'h000;

  // Opcode mask/match pairs for the decoded control-flow instructions.
  localparam logic [11:0] GOTO_MASK   = 12'hE00;
  localparam logic [11:0] GOTO_MATCH  = 12'hA00;
  localparam logic [11:0] CALL_MASK   = 12'hF00;
  localparam logic [11:0] CALL_MATCH  = 12'h900;
  localparam logic [11:0] RETLW_MASK  = 12'hF00;
  localparam logic [11:0] RETLW_MATCH = 12'h800;

  typedef enum logic [2:0] {
    FLOW_SEQ  = 3'd0,
    FLOW_GOTO = 3'd1,
    FLOW_CALL = 3'd2,
    FLOW_RET  = 3'd3,
    FLOW_PCL  = 3'd4,
    FLOW_SKIP = 3'd5
  } flow_e;

  // Pick the control-flow action for this cycle. Only a real instruction is
  // decoded; execute-side requests rank below it, PCL writes above skips.
  function automatic flow_e classify_flow(input logic        valid,
                                          input logic [11:0] instr,
                                          input logic        pcl_wr,
                                          input logic        skip);
    flow_e kind;
    if (valid && ((instr & GOTO_MASK) == GOTO_MATCH)) begin
      kind = FLOW_GOTO;
    end else if (valid && ((instr & CALL_MASK) == CALL_MATCH)) begin
      kind = FLOW_CALL;
    end else if (valid && ((instr & RETLW_MASK) == RETLW_MATCH)) begin
      kind = FLOW_RET;
    end else if (pcl_wr) begin
      kind = FLOW_PCL;
    end else if (skip) begin
      kind = FLOW_SKIP;
    end else begin
      kind = FLOW_SEQ;
    end
    return kind;
  endfunction

endpackage

// File: rtl/pic_call_stack.sv
// Two-level hardware return stack: shift-register entries, a saturating
// occupancy counter and sticky overflow/underflow indicators.
module pic_call_stack #(
  parameter int unsigned ADDR_W      = pic_pkg::ADDR_W,
  parameter int unsigned STACK_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [1:0]        depth_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam logic [1:0] DEPTH_MAX = 2'(STACK_DEPTH);

  logic [ADDR_W-1:0] stk0_q, stk0_d;
  logic [ADDR_W-1:0] stk1_q, stk1_d;
  logic [1:0]        depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // Next-state for push/pop; a push when full drops the oldest entry, a pop
  // when empty still shifts (returning whatever stk0 held) and flags it.
  always_comb begin
    stk0_d  = stk0_q;
    stk1_d  = stk1_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_i) begin
      stk1_d = stk0_q;
      stk0_d = push_data_i;
      if (depth_q == DEPTH_MAX) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + 2'd1;
      end
    end else if (pop_i) begin
      stk0_d = stk1_q;
      if (depth_q == 2'd0) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - 2'd1;
      end
    end else begin
      depth_d = depth_q;
    end
  end

  // Stack state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk0_q  <= {ADDR_W{1'b0}};
      stk1_q  <= {ADDR_W{1'b0}};
      depth_q <= 2'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stk0_q  <= stk0_d;
      stk1_q  <= stk1_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top_o   = stk0_q;
  assign depth_o = depth_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/pic_fetch_ctrl.sv
// Fetch/sequencing controller: program counter, execute-stage instruction
// register and control-flow resolution. Taken transfers flush the word
// fetched in the same cycle, so they cost one bubble.
module pic_fetch_ctrl #(
  parameter int unsigned       ADDR_W      = pic_pkg::ADDR_W,
  parameter int unsigned       INSTR_W     = pic_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}},
  parameter int unsigned       STACK_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall_i,
  input  logic               skip_i,
  input  logic               pcl_wr_i,
  input  logic [7:0]         pcl_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic [1:0]         stack_depth_o,
  output logic               stack_ovf_o,
  output logic               stack_unf_o
);

  import pic_pkg::*;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;

  flow_e              flow_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  target_s;
  logic               flush_s;
  logic               push_s;
  logic               pop_s;
  logic [ADDR_W-1:0]  ret_addr_s;
  logic [ADDR_W-1:0]  stk_top_s;

  // Resolve the control-flow action, its target and the pipeline update;
  // a stall freezes every register and suppresses stack side effects.
  always_comb begin
    pc_inc_s   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    ret_addr_s = ipc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    flow_s     = classify_flow(valid_q, ir_q, pcl_wr_i, skip_i);
    target_s   = pc_inc_s;
    flush_s    = 1'b1;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    case (flow_s)
      FLOW_GOTO: target_s = ir_q[ADDR_W-1:0];
      FLOW_CALL: begin
        target_s = ADDR_W'(ir_q[7:0]);
        push_s   = !stall_i;
      end
      FLOW_RET: begin
        target_s = stk_top_s;
        pop_s    = !stall_i;
      end
      FLOW_PCL:  target_s = ADDR_W'(pcl_data_i);
      FLOW_SKIP: target_s = pc_inc_s;
      FLOW_SEQ:  flush_s  = 1'b0;
      default: begin
        target_s = pc_inc_s;
        flush_s  = 1'b1;
      end
    endcase

    if (stall_i) begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      valid_d = valid_q;
      ipc_d   = ipc_q;
    end else begin
      pc_d    = target_s;
      ir_d    = flush_s ? NOP : rom_data;
      valid_d = !flush_s;
      ipc_d   = pc_q;
    end
  end

  // Pipeline registers: PC plus the execute-stage instruction and its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      ir_q    <= NOP;
      valid_q <= 1'b0;
      ipc_q   <= {ADDR_W{1'b0}};
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
    end
  end

  pic_call_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (ret_addr_s),
    .top_o       (stk_top_s),
    .depth_o     (stack_depth_o),
    .ovf_o       (stack_ovf_o),
    .unf_o       (stack_unf_o)
  );

  assign rom_addr      = pc_q;
  assign instr_o       = ir_q;
  assign instr_valid_o = valid_q;
  assign instr_pc_o    = ipc_q;

endmodule

// File: tb/tb_pic_fetch_ctrl.sv
// Bench for pic_fetch_ctrl: directed scenarios plus a randomized program run,
// all compared against a cycle-level behavioural model of fetch/sequencing.
module tb_pic_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic        stall_i, skip_i, pcl_wr_i;
  logic [7:0]  pcl_data_i;
  logic [11:0] instr_o;
  logic        instr_valid_o;
  logic [8:0]  instr_pc_o;
  logic [1:0]  stack_depth_o;
  logic        stack_ovf_o, stack_unf_o;

  logic [11:0] rom_mem [0:511];
  assign rom_data = rom_mem[rom_addr];

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_pc, m_ir, m_valid, m_ipc, m_depth, m_ovf, m_unf;
  int m_stk [2];

  always #5 clk = ~clk;

  pic_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .stall_i       (stall_i),
    .skip_i        (skip_i),
    .pcl_wr_i      (pcl_wr_i),
    .pcl_data_i    (pcl_data_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_pc_o    (instr_pc_o),
    .stack_depth_o (stack_depth_o),
    .stack_ovf_o   (stack_ovf_o),
    .stack_unf_o   (stack_unf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rom_addr", 32'(rom_addr), m_pc);
    chk("instr", 32'(instr_o), m_ir);
    chk("valid", 32'(instr_valid_o), m_valid);
    chk("instr_pc", 32'(instr_pc_o), m_ipc);
    chk("depth", 32'(stack_depth_o), m_depth);
    chk("ovf", 32'(stack_ovf_o), m_ovf);
    chk("unf", 32'(stack_unf_o), m_unf);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_valid = 0; m_ipc = 0;
    m_depth = 0; m_ovf = 0; m_unf = 0;
    m_stk[0] = 0; m_stk[1] = 0;
  endtask

  // One clock of the architectural behaviour, computed from the rules.
  task automatic model_step(input bit stall, input bit skip, input bit pclw, input int pd);
    int nxt;
    bit flush;
    if (!stall) begin
      flush = 1'b1;
      if (m_valid == 1 && m_ir >= 'hA00 && m_ir <= 'hBFF) begin
        nxt = m_ir % 512;
      end else if (m_valid == 1 && m_ir >= 'h900 && m_ir <= 'h9FF) begin
        nxt = m_ir % 256;
        m_stk[1] = m_stk[0];
        m_stk[0] = (m_ipc + 1) % 512;
        if (m_depth == 2) m_ovf = 1; else m_depth = m_depth + 1;
      end else if (m_valid == 1 && m_ir >= 'h800 && m_ir <= 'h8FF) begin
        nxt = m_stk[0];
        m_stk[0] = m_stk[1];
        if (m_depth == 0) m_unf = 1; else m_depth = m_depth - 1;
      end else if (pclw) begin
        nxt = pd;
      end else if (skip) begin
        nxt = (m_pc + 1) % 512;
      end else begin
        nxt = (m_pc + 1) % 512;
        flush = 1'b0;
      end
      m_ir    = flush ? 0 : int'(rom_mem[m_pc]);
      m_valid = flush ? 0 : 1;
      m_ipc   = m_pc;
      m_pc    = nxt;
    end
  endtask

  // Drive inputs at a falling edge, advance one rising edge, check at the next falling edge.
  task automatic cycle(input bit stall, input bit skip, input bit pclw, input logic [7:0] pd);
    stall_i = stall; skip_i = skip; pcl_wr_i = pclw; pcl_data_i = pd;
    model_step(stall, skip, pclw, int'(pd));
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 512; a++) rom_mem[a] = 12'h000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 1'b0; skip_i = 1'b0; pcl_wr_i = 1'b0; pcl_data_i = 8'h00;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; skip_i = 1'b0; pcl_wr_i = 1'b0; pcl_data_i = 8'h00;
    clear_rom();
    @(negedge clk);

    // Fill latency and straight-line issue, then GOTO chain
    rom_mem[0] = 12'hC09; rom_mem[1] = 12'h028; rom_mem[2] = 12'hA1F;
    rom_mem[9'h01F] = 12'hA25;
    do_reset();
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    run(1);
    chk("fill_instr", 32'(instr_o), 32'hC09);
    chk("fill_pc", 32'(instr_pc_o), 32'h0);
    chk("fill_rom_addr", 32'(rom_addr), 32'h1);
    run(1);
    chk("seq_instr", 32'(instr_o), 32'h028);
    chk("seq_pc", 32'(instr_pc_o), 32'h1);
    run(4);
    chk("goto_bubble", 32'(instr_valid_o), 32'h0);
    chk("goto_target", 32'(rom_addr), 32'h025);
    run(1);
    chk("goto_landed_pc", 32'(instr_pc_o), 32'h025);
    chk("goto_landed_valid", 32'(instr_valid_o), 32'h1);

    // CALL then RETLW
    clear_rom();
    rom_mem[0] = 12'hA10; rom_mem[9'h010] = 12'h905; rom_mem[5] = 12'h8AA;
    do_reset();
    run(4);
    chk("call_depth", 32'(stack_depth_o), 32'h1);
    chk("call_target", 32'(rom_addr), 32'h005);
    run(2);
    chk("ret_bubble", 32'(instr_valid_o), 32'h0);
    run(1);
    chk("ret_pc", 32'(instr_pc_o), 32'h011);
    chk("ret_depth", 32'(stack_depth_o), 32'h0);
    chk("ret_flags", 32'({stack_ovf_o, stack_unf_o}), 32'h0);

    // Nested CALLs overflow, RETLWs unwind and underflow
    clear_rom();
    rom_mem[0] = 12'hA10; rom_mem[9'h010] = 12'h920; rom_mem[9'h020] = 12'h930;
    rom_mem[9'h030] = 12'h940; rom_mem[9'h040] = 12'h800;
    rom_mem[9'h031] = 12'h800; rom_mem[9'h021] = 12'h800;
    do_reset();
    run(8);
    chk("nest_ovf", 32'(stack_ovf_o), 32'h1);
    chk("nest_depth", 32'(stack_depth_o), 32'h2);
    run(3);
    chk("ret1_pc", 32'(instr_pc_o), 32'h031);
    run(2);
    chk("ret2_pc", 32'(instr_pc_o), 32'h021);
    chk("ret2_unf", 32'(stack_unf_o), 32'h0);
    run(2);
    chk("ret3_pc", 32'(instr_pc_o), 32'h021);
    chk("ret3_unf", 32'(stack_unf_o), 32'h1);

    // Skip turns the next fetched word into a bubble
    clear_rom();
    rom_mem[0] = 12'hA1E; rom_mem[9'h01F] = 12'hC77;
    do_reset();
    chk("flags_cleared", 32'({stack_ovf_o, stack_unf_o}), 32'h0);
    run(3);
    chk("skip_setup_pc", 32'(instr_pc_o), 32'h01E);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("skip_bubble_valid", 32'(instr_valid_o), 32'h0);
    chk("skip_bubble_instr", 32'(instr_o), 32'h000);
    run(1);
    chk("skip_next_pc", 32'(instr_pc_o), 32'h020);

    // Stall at the top of program space, wrap, then async reset mid-stall
    clear_rom();
    rom_mem[0] = 12'hBFF; rom_mem[9'h1FF] = 12'hC55;
    do_reset();
    run(3);
    chk("stall_setup_pc", 32'(instr_pc_o), 32'h1FF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      chk("stall_frozen_pc", 32'(instr_pc_o), 32'h1FF);
      chk("stall_frozen_instr", 32'(instr_o), 32'hC55);
    end
    run(1);
    chk("wrap_pc", 32'(instr_pc_o), 32'h000);
    stall_i = 1'b1; skip_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    stall_i = 1'b0; skip_i = 1'b0;

    // Randomized program and execute-side requests
    for (int a = 0; a < 512; a++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0:       rom_mem[a] = 12'hA00 | 12'($urandom_range(0, 511));
        1:       rom_mem[a] = 12'h900 | 12'($urandom_range(0, 255));
        2:       rom_mem[a] = 12'h800 | 12'($urandom_range(0, 255));
        default: rom_mem[a] = 12'($urandom_range(0, 4095));
      endcase
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit st, sk, pw;
      st = ($urandom_range(0, 99) < 20);
      sk = ($urandom_range(0, 99) < 15);
      pw = ($urandom_range(0, 99) < 10);
      cycle(st, sk, pw, 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
